// File: rtl/sync_bytemask_ram_pkg.sv
// sync_bytemask_ram_pkg: shared state encoding and lane-count helper for sync_bytemask_ram
package sync_bytemask_ram_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} ram_state_e;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/sync_bytemask_ram_lane.sv
// sync_bytemask_ram_lane: one 8-bit byte lane (clk, rst_n, we_i, re_i, addr_i, wdata_i -> rdata_o) with sync write and registered read
module sync_bytemask_ram_lane #(
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [1<<IW];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) if (we_i) mem_q[addr_i] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_bytemask_ram.sv
// sync_bytemask_ram: byte-strobed single-port RAM (clk, resetn, req_* valid/ready in, resp_* valid/ready out, init_done) with clear-on-reset
module sync_bytemask_ram
  import sync_bytemask_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    init_done
);
  localparam int BYTES = lanes(DATA_WIDTH);
  localparam int IW    = ADDR_WIDTH - OFFSET;
  ram_state_e    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, idx;
  logic          resp_valid_q, resp_valid_d, run, accept, rd_acc, unused_lo;
  assign run       = state_q == ST_RUN;
  assign req_ready = resetn && run && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && ~|req_we;
  // during INIT the clear counter owns the address port
  assign idx       = run ? req_addr[ADDR_WIDTH-1:OFFSET] : cnt_q;
  assign unused_lo = ^req_addr[OFFSET-1:0];
  always_comb begin
    state_d      = (!run && &cnt_q) ? ST_RUN : state_q;
    cnt_d        = run ? cnt_q : cnt_q + 1'b1;
    resp_valid_d = rd_acc || (resp_valid_q && !resp_ready);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
    end
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    sync_bytemask_ram_lane #(.IW(IW)) u_lane (
      .clk     (clk),
      .rst_n   (resetn),
      .we_i    (run ? (accept && req_we[i]) : 1'b1),
      .re_i    (rd_acc),
      .addr_i  (idx),
      .wdata_i (run ? req_wdata[8*i+:8] : 8'h00),
      .rdata_o (resp_rdata[8*i+:8])
    );
  end
  assign resp_valid = resp_valid_q;
  assign init_done  = run;
endmodule

// File: tb/tb_sync_bytemask_ram.sv
// tb_sync_bytemask_ram: scoreboard bench for sync_bytemask_ram with default parameters
module tb_sync_bytemask_ram;
  logic        clk = 0, resetn, req_valid, req_ready, resp_valid, resp_ready, init_done;
  logic [3:0]  req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [31:0] model [1024];
  logic [31:0] sb [$];
  int          total = 0, bad = 0, cyc = 0, last_cyc = -10, streak = 0;

  sync_bytemask_ram dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (resetn && resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("unexpected_resp", resp_rdata, 32'hx);
      else chk("rdata", resp_rdata, sb.pop_front());
      streak   = (cyc == last_cyc + 1) ? streak + 1 : 1;
      last_cyc = cyc;
    end

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) model[i] = '0;
  endtask

  task automatic issue(input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_timeout", n, 0);
    if (we == 0) sb.push_back(model[a[11:2]]);
    else for (int b = 0; b < 4; b++) if (we[b]) model[a[11:2]][8*b+:8] = d[8*b+:8];
    @(posedge clk); #2;
    req_valid = 0; req_we = 0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    chk({tag, "_ready_low"}, req_ready, 0);
    while (!init_done && n < 3000) begin
      @(posedge clk);
      n++;
      #1;
    end
    req_valid = 0;
    #1;
    chk({tag, "_cycles"}, n, 1024);
  endtask

  initial begin
    resetn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    clear_model();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", init_done, 0);
    resetn = 1;
    wait_init("init1");
    issue(4'h0, 12'h000, 0);
    issue(4'h0, 12'h7FC, 0);
    issue(4'h0, 12'hFFC, 0);
    drain();
    issue(4'hF, 12'h010, 32'hAABBCCDD);
    issue(4'h5, 12'h010, 32'h11223344);
    issue(4'hF, 12'h014, 32'h55667788);
    issue(4'h8, 12'h01C, 32'h99000000);
    issue(4'h3, 12'h018, 32'h0000BEEF);
    drain();
    chk("idle_valid", resp_valid, 0);
    issue(4'h0, 12'h010, 0);
    chk("latency1", resp_valid, 1);
    chk("strobe_word", resp_rdata, 32'hAA22CC44);
    drain();
    resp_ready = 0;
    issue(4'h0, 12'h010, 0);
    req_valid = 1; req_we = 0; req_addr = 12'h014;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", req_ready, 0);
      chk("stall_hold", resp_rdata, 32'hAA22CC44);
    end
    @(posedge clk); #2;
    resp_ready = 1;
    sb.push_back(model[5]);
    @(negedge clk);
    chk("unstall_ready", req_ready, 1);
    @(posedge clk); #2;
    req_valid = 0;
    drain();
    chk("bp_sb_empty", sb.size(), 0);
    for (int i = 0; i < 8; i++) issue(4'h0, 12'(i * 4), 0);
    drain();
    chk("throughput_streak", streak, 8);
    issue(4'hF, 12'h020, 32'hDEADBEEF);
    issue(4'h0, 12'h020, 0);
    issue(4'h0, 12'h023, 0);
    drain();
    chk("raw_word", resp_rdata, 32'hDEADBEEF);
    resp_ready = 0;
    issue(4'h0, 12'h020, 0);
    chk("pre_rst_valid", resp_valid, 1);
    #3;
    resetn = 0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_done", init_done, 0);
    chk("mid_rst_ready", req_ready, 0);
    sb.delete();
    clear_model();
    @(posedge clk); #2;
    resetn = 1;
    req_valid = 1; req_we = 4'hF; req_addr = 'x; req_wdata = 'x;
    resp_ready = 1;
    wait_init("init2");
    issue(4'h0, 12'h020, 0);
    issue(4'h0, 12'h7FC, 0);
    drain();
    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/sync_bytemask_ram.md
Name: sync_bytemask_ram

Overview:
- Parametrised synchronous successor to the 4 KB combinational data RAM.
- Single-port memory built from byte lanes, with per-byte write strobes and a one-cycle registered read.
- Uses a valid/ready request/response handshake with back-pressure, plus a hardware clear-on-reset sequencer.
- Sits between the MEM stage and the on-chip data store; the MEM stage sees the same byte-select semantics as before, now clocked and stallable.

Parameters:
- ADDR_WIDTH, 12, byte-address width; depth in words = 2^(ADDR_WIDTH-OFFSET).
- DATA_WIDTH, 32, word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- OFFSET, 2, log2(BYTES); byte-offset bits ignored for indexing.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  BYTES  per-byte write strobe; all zero = read.
- req_addr  in  ADDR_WIDTH  byte address; word index = req_addr[ADDR_WIDTH-1:OFFSET].
- req_wdata  in  DATA_WIDTH  write data; lane i = bits [8i+7:8i].
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes read data.
- resp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  high once the clear sequence has finished (RUN state).

Behaviour:
- Reset (resetn low, async): state=INIT if CLEAR_ON_RESET else RUN; clear counter=0; resp_valid=0; resp_rdata=0; init_done=0 (1 if CLEAR_ON_RESET=0); req_ready=0. Memory contents are not reset asynchronously.
- INIT: one word per cycle; word[cnt] <= 0 on every lane, cnt++. After writing the last index (DEPTH-1), next state=RUN. INIT lasts exactly DEPTH cycles; req_ready=0 throughout; requests are ignored.
- RUN: init_done=1; req_ready = !resp_valid || resp_ready.
- Accept = req_valid && req_ready. One request per cycle (single port).
- Write (req_we != 0): at the accepting edge, lanes with req_we[i]=1 are updated and the rest are unchanged. No response is generated. Partial strobes (e.g. 4'b0011, 4'b1000) are legal.
- Read (req_we == 0): data registered at the accepting edge; resp_valid=1 and resp_rdata=word from the next cycle (latency 1).
- Read-after-write to the same word in consecutive cycles returns the new data, because the write has committed at the earlier edge.
- Response register: set on an accepted read. Cleared when resp_valid && resp_ready with no new read accepted. If resp_ready && new read accepted in the same cycle, it is reloaded (back-to-back reads at full throughput).
- Stall: resp_valid && !resp_ready forces req_ready=0, and resp_rdata is held stable until taken. This holds for writes too.
- Address: upper bits beyond ADDR_WIDTH do not exist; the low OFFSET bits are ignored (no misalignment fault; alignment is the MEM stage's job). Index wrap is natural modulo depth.
- Reset asserted mid-operation: any pending response is dropped (resp_valid=0 immediately) and the clear sequence restarts from index 0. A write in flight at the reset edge is not guaranteed.
- req_valid with X fields while req_ready=0 must not corrupt memory.

Decomposition:
- defines.vh additions: RAM_STATE_INIT/RAM_STATE_RUN encodings, default RAM_ADDR_WIDTH/RAM_DATA_WIDTH, and the BYTES/OFFSET derivation macro.
- Sub-module ram_byte_lane: one 8-bit-wide, 2^(ADDR_WIDTH-OFFSET)-deep array with sync write enable and sync read. Instantiated BYTES times via generate.
- The top holds the FSM, clear counter, handshake and response register.

Test Plan:
- Clear: CLEAR_ON_RESET=1, default params. Release resetn; init_done rises after exactly 1024 cycles. Read 0x000, 0x7FC, 0xFFC -> all 0x00000000.
- Byte strobes: write 0xAABBCCDD to 0x010 with we=4'b1111, then 0x11223344 with we=4'b0101 -> read 0x010 returns 0xAA22CC44, with resp_valid exactly one cycle after acceptance.
- Back-pressure: issue reads to 0x010 and 0x014 back-to-back with resp_ready=0 for 3 cycles -> req_ready=0 during the stall, resp_rdata held at the first word; after resp_ready=1 both words delivered in order, none lost or duplicated.
- Full throughput: resp_ready=1, 8 consecutive reads to 0x000..0x01C -> 8 responses on 8 consecutive cycles, each word matching.
- Read-after-write: write 0xDEADBEEF to 0x020, read 0x020 next cycle -> 0xDEADBEEF. Misaligned read of 0x023 -> same word.
- Reset mid-stall: resp_valid=1, resp_ready=0, pulse resetn low -> resp_valid=0 asynchronously, init_done=0, clear restarts; after completion, 0x020 reads 0.
